// File: rtl/pwm_cfg_sched.sv
// pwm_cfg_sched: round-robin scheduler that hands PWM duty/frequency updates from NREQ
// requesters to a PWM generator. An update is only applied on a sawtooth period boundary,
// so the generator never sees a mid-period change.
//
// Optional build macro: PWM_CFG_SCHED_RAMP_EN. When it is defined, the duty output slews by
// one step per period instead of jumping to the requested value.
//
// Ports:
//   i_clk          clock, all state on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req          per-requester update request, held until acknowledged
//   i_duty_req     requester i duty at [i*W +: W]
//   i_freq_req     requester i frequency at [i*W +: W]
//   i_sawtooth     sawtooth feedback from the generator
//   o_grant        one-hot winner, held from grant until apply or abort
//   o_ack          one-cycle pulse to the winner when its config is applied
//   o_signal_out   duty value driven into the generator
//   o_freq_out     frequency value driven into the generator
//   o_busy         high whenever the scheduler is not idle
module pwm_cfg_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned DUTY_RST = 0,
  parameter int unsigned FREQ_RST = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_duty_req,
  input  logic [NREQ*W-1:0] i_freq_req,
  input  logic [W-1:0]      i_sawtooth,
  output logic [NREQ-1:0]   o_grant,
  output logic [NREQ-1:0]   o_ack,
  output logic [W-1:0]      o_signal_out,
  output logic [W-1:0]      o_freq_out,
  output logic              o_busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef PWM_CFG_SCHED_RAMP_EN
  typedef enum logic [1:0] {StIdle, StPend, StApply, StRamp} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPend, StApply} state_e;
`endif

  state_e          r_state, w_state_d;
  logic [NREQ-1:0] r_grant, w_grant_d;
  logic [NREQ-1:0] r_ack, w_ack_d;
  logic [W-1:0]    r_signal, w_signal_d;
  logic [W-1:0]    r_freq, w_freq_d;
  logic [W-1:0]    r_shadow_duty, w_shadow_duty_d;
  logic [W-1:0]    r_shadow_freq, w_shadow_freq_d;
  logic [W-1:0]    r_saw_prev;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_d;
  logic [PW-1:0]   r_winner, w_winner_d;
  logic            r_busy;

  logic [PW-1:0]   w_pick, w_idx, w_winner_inc;
  logic [W-1:0]    w_duty_pick, w_freq_pick;
  logic            w_wrap, w_any_req, w_abort, w_apply;

  // A period boundary is a descent of the sawtooth relative to the previous cycle.
  assign w_wrap       = i_sawtooth < r_saw_prev;
  assign w_any_req    = |i_req;
  assign w_abort      = ~i_req[r_winner];
  assign w_winner_inc = (r_winner == PW'(NREQ - 1)) ? '0 : r_winner + 1'b1;
  assign w_duty_pick  = i_duty_req[w_pick*W +: W];
  assign w_freq_pick  = i_freq_req[w_pick*W +: W];

`ifdef PWM_CFG_SCHED_RAMP_EN
  logic [W-1:0] w_step;
  assign w_step = (r_signal < r_shadow_duty) ? r_signal + 1'b1 : r_signal - 1'b1;
`endif

  // Round-robin pick: scan from the highest offset down so the first requester at or
  // after r_rr_ptr is the last one written.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = PW'((32'(r_rr_ptr) + 32'(k)) % NREQ);
      if (i_req[w_idx]) w_pick = w_idx;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_grant_d       = r_grant;
    w_ack_d         = '0;
    w_signal_d      = r_signal;
    w_freq_d        = r_freq;
    w_shadow_duty_d = r_shadow_duty;
    w_shadow_freq_d = r_shadow_freq;
    w_rr_ptr_d      = r_rr_ptr;
    w_winner_d      = r_winner;
    w_apply         = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_d         = StPend;
          w_grant_d         = '0;
          w_grant_d[w_pick] = 1'b1;
          w_winner_d        = w_pick;
          w_shadow_duty_d   = w_duty_pick;
          // A zero period is never handed to the generator.
          w_shadow_freq_d   = (w_freq_pick == '0) ? W'(1) : w_freq_pick;
        end
      end
      StPend: begin
        // Abort outranks a coincident wrap.
        if (w_abort) begin
          w_state_d = StIdle;
          w_grant_d = '0;
        end else if (w_wrap) begin
          w_freq_d = r_shadow_freq;
`ifdef PWM_CFG_SCHED_RAMP_EN
          if (r_signal == r_shadow_duty) begin
            w_apply = 1'b1;
          end else begin
            w_signal_d = w_step;
            if (w_step == r_shadow_duty) w_apply = 1'b1;
            else                         w_state_d = StRamp;
          end
`else
          w_signal_d = r_shadow_duty;
          w_apply    = 1'b1;
`endif
        end
      end
`ifdef PWM_CFG_SCHED_RAMP_EN
      StRamp: begin
        // On abort the partially ramped duty is kept.
        if (w_abort) begin
          w_state_d = StIdle;
          w_grant_d = '0;
        end else if (w_wrap) begin
          w_signal_d = w_step;
          if (w_step == r_shadow_duty) w_apply = 1'b1;
        end
      end
`endif
      StApply: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_apply) begin
      w_state_d  = StApply;
      w_ack_d    = r_grant;
      w_grant_d  = '0;
      w_rr_ptr_d = w_winner_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_grant       <= '0;
      r_ack         <= '0;
      r_signal      <= W'(DUTY_RST);
      r_freq        <= W'(FREQ_RST);
      r_shadow_duty <= '0;
      r_shadow_freq <= '0;
      r_saw_prev    <= '0;
      r_rr_ptr      <= '0;
      r_winner      <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_grant       <= w_grant_d;
      r_ack         <= w_ack_d;
      r_signal      <= w_signal_d;
      r_freq        <= w_freq_d;
      r_shadow_duty <= w_shadow_duty_d;
      r_shadow_freq <= w_shadow_freq_d;
      r_saw_prev    <= i_sawtooth;
      r_rr_ptr      <= w_rr_ptr_d;
      r_winner      <= w_winner_d;
      r_busy        <= (w_state_d != StIdle);
    end
  end

  assign o_grant      = r_grant;
  assign o_ack        = r_ack;
  assign o_signal_out = r_signal;
  assign o_freq_out   = r_freq;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_pwm_cfg_sched.sv
// tb_pwm_cfg_sched: self-checking bench for pwm_cfg_sched. Directed scenarios followed by a
// randomized run checked against a transaction-level model (round-robin order, applied
// duty/frequency values, abort behaviour). Follows PWM_CFG_SCHED_RAMP_EN if defined.
module tb_pwm_cfg_sched;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned W        = 8;
  localparam int unsigned DUTY_RST = 0;
  localparam int unsigned FREQ_RST = 10;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic [NREQ-1:0]   req      = '0;
  logic [NREQ*W-1:0] duty_req = '0;
  logic [NREQ*W-1:0] freq_req = '0;
  logic [W-1:0]      saw      = '0;
  logic [NREQ-1:0]   grant, ack;
  logic [W-1:0]      sig_out, freq_out;
  logic              busy;

  pwm_cfg_sched #(
    .NREQ(NREQ), .W(W), .DUTY_RST(DUTY_RST), .FREQ_RST(FREQ_RST)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_duty_req(duty_req),
    .i_freq_req(freq_req), .i_sawtooth(saw), .o_grant(grant), .o_ack(ack),
    .o_signal_out(sig_out), .o_freq_out(freq_out), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int period  = 10;
  logic [W-1:0] edge_saw  = '0;
  logic         wrap_edge = 1'b0;
  int           model_rr  = 0;
  logic [W-1:0] model_sig = W'(DUTY_RST);
  logic [W-1:0] model_freq = W'(FREQ_RST);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Model: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int ptr);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] fix_freq(input logic [W-1:0] f);
    return (f == '0) ? W'(1) : f;
  endfunction

  function automatic int ack_bound();
`ifdef PWM_CFG_SCHED_RAMP_EN
    return 20 * period + 4;
`else
    return period + 3;
`endif
  endfunction

  task automatic set_cfg(input int i, input logic [W-1:0] d, input logic [W-1:0] f);
    duty_req[i*W +: W] = d;
    freq_req[i*W +: W] = f;
  endtask

  // One clock; records whether this edge was a period boundary, then advances the sawtooth.
  task automatic tick();
    logic [W-1:0] prev;
    prev = edge_saw;
    @(posedge clk);
    if (!rst_n) begin
      edge_saw  = '0;
      wrap_edge = 1'b0;
    end else begin
      edge_saw  = saw;
      wrap_edge = (saw < prev);
    end
    #1;
    saw = W'((int'(saw) + 1) % period);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n      = 1'b1;
    req        = '0;
    model_rr   = 0;
    model_sig  = W'(DUTY_RST);
    model_freq = W'(FREQ_RST);
  endtask

  // Waits for an ack; notes wraps seen and any output change on a non-wrap edge.
  task automatic wait_ack(input int bound, output int cyc, output int wraps, output bit mid);
    logic [W-1:0] sb, fb;
    cyc = 0; wraps = 0; mid = 1'b0;
    while (ack == '0 && cyc < bound) begin
      sb = sig_out;
      fb = freq_out;
      tick();
      cyc++;
      if (wrap_edge) wraps++;
      if (!wrap_edge && (sig_out != sb || freq_out != fb)) mid = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit bad;
    req   = '0;
    rst_n = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (sig_out !== W'(DUTY_RST)) begin
      n_fail++; $display("FAIL reset_signal: got %0d expected %0d", sig_out, DUTY_RST);
    end
    n_tests++;
    if (freq_out !== W'(FREQ_RST)) begin
      n_fail++; $display("FAIL reset_freq: got %0d expected %0d", freq_out, FREQ_RST);
    end
    n_tests++;
    if (grant !== '0 || ack !== '0) begin
      n_fail++; $display("FAIL reset_grant_ack: got %b/%b expected 0/0", grant, ack);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    rst_n = 1'b1;
    bad   = 1'b0;
    repeat (3 * period) begin
      tick();
      if (sig_out !== W'(DUTY_RST) || freq_out !== W'(FREQ_RST) || grant !== '0 || busy)
        bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL idle_after_reset: got a change expected none");
    end
  endtask

  task automatic test_single();
    int cyc, wraps;
    bit mid;
    set_cfg(0, 8'd5, 8'd10);
    req = 4'b0001;
    tick();
    n_tests++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: got %b busy %b expected 0001 busy 1", grant, busy);
    end
    wait_ack(ack_bound(), cyc, wraps, mid);
    n_tests++;
    if (ack !== 4'b0001) begin
      n_fail++; $display("FAIL single_ack: got %b expected 0001", ack);
    end
    n_tests++;
    if (sig_out !== 8'd5 || freq_out !== 8'd10) begin
      n_fail++; $display("FAIL single_apply: got %0d/%0d expected 5/10", sig_out, freq_out);
    end
    n_tests++;
    if (wrap_edge !== 1'b1 || mid) begin
      n_fail++; $display("FAIL single_on_wrap: got wrap %b mid %b expected 1 0", wrap_edge, mid);
    end
    req = '0;
    tick();
    n_tests++;
    if (ack !== '0 || grant !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got %b/%b/%b expected 0/0/0", ack, grant, busy);
    end
    model_rr = 1; model_sig = 8'd5; model_freq = 8'd10;
  endtask

  task automatic test_round_robin();
    int cyc, wraps, exp;
    bit mid;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cfg(i, W'(i + 1), W'(20 + i));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp = rr_pick(req, model_rr);
      wait_ack(ack_bound() + 2, cyc, wraps, mid);
      n_tests++;
      if (ack !== onehot(exp)) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", n, ack, onehot(exp));
      end
      n_tests++;
      if (sig_out !== W'(exp + 1) || freq_out !== W'(20 + exp)) begin
        n_fail++; $display("FAIL rr_value[%0d]: got %0d/%0d expected %0d/%0d",
                           n, sig_out, freq_out, exp + 1, 20 + exp);
      end
`ifndef PWM_CFG_SCHED_RAMP_EN
      n_tests++;
      if (wraps != 1) begin
        n_fail++; $display("FAIL rr_per_wrap[%0d]: got %0d wraps expected 1", n, wraps);
      end
`endif
      model_rr = (exp + 1) % NREQ;
      if (n == 4) req = '0;
      tick();
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle: got busy %b expected 0", busy);
    end
    model_sig = 8'd1; model_freq = 8'd20;
  endtask

  task automatic test_freq_zero();
    int cyc, wraps;
    bit mid;
    set_cfg(1, 8'd6, 8'd0);
    req = 4'b0010;
    tick();
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++; $display("FAIL fz_grant: got %b expected 0010", grant);
    end
    wait_ack(ack_bound(), cyc, wraps, mid);
    n_tests++;
    if (ack !== 4'b0010 || freq_out !== 8'd1 || sig_out !== 8'd6) begin
      n_fail++; $display("FAIL fz_apply: got ack %b freq %0d sig %0d expected 0010 1 6",
                         ack, freq_out, sig_out);
    end
    req = '0;
    tick();
    model_rr = 2; model_sig = 8'd6; model_freq = 8'd1;
  endtask

  task automatic test_abort();
    int cyc, wraps, guard, exp;
    bit mid, bad;
    guard = 0;
    while (saw != 2 && guard < 64) begin tick(); guard++; end
    set_cfg(2, 8'd12, 8'h55);
    req = 4'b0100;
    tick();
    n_tests++;
    if (grant !== 4'b0100) begin
      n_fail++; $display("FAIL abort_grant: got %b expected 0100", grant);
    end
    tick(); tick();
    req = '0;
    tick();
    n_tests++;
    if (ack !== '0 || grant !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got %b/%b/%b expected 0/0/0", ack, grant, busy);
    end
    bad = 1'b0;
    repeat (2 * period) begin
      tick();
      if (ack !== '0 || sig_out !== model_sig || freq_out !== model_freq || busy) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL abort_quiet: got activity expected none");
    end
    req = 4'b1111;
    tick();
    exp = rr_pick(req, model_rr);
    n_tests++;
    if (grant !== onehot(exp)) begin
      n_fail++; $display("FAIL abort_ptr_kept: got %b expected %b", grant, onehot(exp));
    end
    wait_ack(ack_bound(), cyc, wraps, mid);
    n_tests++;
    if (ack !== 4'b0100 || sig_out !== 8'd12 || freq_out !== 8'h55) begin
      n_fail++; $display("FAIL abort_retry: got %b %0d %0d expected 0100 12 85",
                         ack, sig_out, freq_out);
    end
    req = '0;
    tick();
    model_rr = 3; model_sig = 8'd12; model_freq = 8'h55;
    // Drop the request exactly on the wrap cycle: the abort must win.
    set_cfg(3, 8'd14, 8'h40);
    req = 4'b1000;
    tick();
    n_tests++;
    if (grant !== 4'b1000) begin
      n_fail++; $display("FAIL abortwrap_grant: got %b expected 1000", grant);
    end
    guard = 0;
    while (saw != 0 && guard < 64) begin tick(); guard++; end
    req = '0;
    tick();
    n_tests++;
    if (ack !== '0 || busy !== 1'b0 || sig_out !== model_sig || freq_out !== model_freq) begin
      n_fail++; $display("FAIL abortwrap_prio: got ack %b busy %b %0d/%0d expected 0 0 %0d/%0d",
                         ack, busy, sig_out, freq_out, model_sig, model_freq);
    end
  endtask

  task automatic test_slew();
    int cyc, wraps;
    bit mid, bad;
    logic [W-1:0] seen[$];
    logic [W-1:0] expq[$];
    logic [W-1:0] prev;
    do_reset();
    set_cfg(0, 8'd5, 8'd10);
    req = 4'b0001;
    tick();
    wait_ack(ack_bound(), cyc, wraps, mid);
    n_tests++;
    if (ack !== 4'b0001 || sig_out !== 8'd5) begin
      n_fail++; $display("FAIL slew_setup: got %b %0d expected 0001 5", ack, sig_out);
    end
    req = '0;
    tick();
    set_cfg(0, 8'd9, 8'd10);
    req = 4'b0001;
`ifdef PWM_CFG_SCHED_RAMP_EN
    for (int v = 6; v <= 9; v++) expq.push_back(W'(v));
`else
    expq.push_back(8'd9);
`endif
    prev = sig_out;
    cyc  = 0;
    while (ack == '0 && cyc < 8 * period) begin
      tick();
      cyc++;
      if (sig_out != prev) begin seen.push_back(sig_out); prev = sig_out; end
    end
    bad = (seen.size() != expq.size());
    if (!bad) foreach (expq[i]) if (seen[i] !== expq[i]) bad = 1'b1;
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL slew_sequence: got %0d steps ending %0d expected %0d steps ending 9",
                         seen.size(), sig_out, expq.size());
    end
    n_tests++;
    if (ack !== 4'b0001 || sig_out !== 8'd9) begin
      n_fail++; $display("FAIL slew_ack: got %b %0d expected 0001 9", ack, sig_out);
    end
    req = '0;
    tick();
    model_rr = 1; model_sig = 8'd9; model_freq = 8'd10;
  endtask

  task automatic test_reset_mid_pend();
    bit bad;
    set_cfg(2, 8'd7, 8'h30);
    req = 4'b0100;
    tick();
    n_tests++;
    if (grant !== 4'b0100) begin
      n_fail++; $display("FAIL rstpend_grant: got %b expected 0100", grant);
    end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (grant !== '0 || busy !== 1'b0 || sig_out !== W'(DUTY_RST) || freq_out !== W'(FREQ_RST))
    begin
      n_fail++; $display("FAIL rstpend_async: got %b %b %0d %0d expected 0 0 %0d %0d",
                         grant, busy, sig_out, freq_out, DUTY_RST, FREQ_RST);
    end
    req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    bad   = 1'b0;
    repeat (2 * period) begin
      tick();
      if (ack !== '0 || sig_out !== W'(DUTY_RST)) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL rstpend_discard: got ack or change expected none");
    end
    model_rr = 0; model_sig = W'(DUTY_RST); model_freq = W'(FREQ_RST);
  endtask

  task automatic test_random();
    int cyc, wraps, exp, d, k;
    bit mid, abort_req;
    logic [NREQ-1:0] mask;
    for (int t = 0; t < 40; t++) begin
      period = $urandom_range(3, 12);
      mask   = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
`ifdef PWM_CFG_SCHED_RAMP_EN
        set_cfg(i, W'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? '0 : W'($urandom));
`else
        set_cfg(i, W'($urandom), ($urandom_range(0, 3) == 0) ? '0 : W'($urandom));
`endif
      end
      exp = rr_pick(mask, model_rr);
      req = mask;
      tick();
      n_tests++;
      if (grant !== onehot(exp)) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", t, grant, onehot(exp));
      end
      abort_req = ($urandom_range(0, 3) == 0);
      if (abort_req) begin
        d = $urandom_range(0, period - 1);
        k = 0;
        while (k < d && ack == '0) begin tick(); k++; end
        abort_req = (ack == '0);
      end
      if (abort_req) begin
        req = '0;
        tick();
        n_tests++;
        if (ack !== '0 || grant !== '0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL rnd_abort[%0d]: got %b/%b/%b expected 0/0/0",
                             t, ack, grant, busy);
        end
`ifndef PWM_CFG_SCHED_RAMP_EN
        n_tests++;
        if (sig_out !== model_sig || freq_out !== model_freq) begin
          n_fail++; $display("FAIL rnd_abort_hold[%0d]: got %0d/%0d expected %0d/%0d",
                             t, sig_out, freq_out, model_sig, model_freq);
        end
`endif
      end else begin
        wait_ack(ack_bound(), cyc, wraps, mid);
        n_tests++;
        if (ack !== onehot(exp)) begin
          n_fail++; $display("FAIL rnd_ack[%0d]: got %b expected %b", t, ack, onehot(exp));
        end
        n_tests++;
        if (sig_out !== duty_req[exp*W +: W] || freq_out !== fix_freq(freq_req[exp*W +: W]))
        begin
          n_fail++; $display("FAIL rnd_value[%0d]: got %0d/%0d expected %0d/%0d", t, sig_out,
                             freq_out, duty_req[exp*W +: W], fix_freq(freq_req[exp*W +: W]));
        end
        n_tests++;
        if (mid) begin
          n_fail++; $display("FAIL rnd_midperiod[%0d]: got change off-wrap expected none", t);
        end
        model_rr   = (exp + 1) % NREQ;
        model_sig  = duty_req[exp*W +: W];
        model_freq = fix_freq(freq_req[exp*W +: W]);
        req = '0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || grant !== '0) begin
          n_fail++; $display("FAIL rnd_done[%0d]: got busy %b grant %b expected 0 0",
                             t, busy, grant);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_freq_zero();
    test_abort();
    test_slew();
    test_reset_mid_pend();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
